// File: rtl/id_inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// id_inst_queue_pkg
// Shared constants and helpers for the IF->ID instruction queue.
//   IQ_INST_W : width of one instruction lane (32 bits)
//   IQ_NOP    : value driven on id_inst when no instruction is valid
//   lane_bits : width of a lane index; at least 1 so single-lane builds
//               still have a legal vector width
// -----------------------------------------------------------------------------
package id_inst_queue_pkg;

  localparam int IQ_INST_W = 32;
  localparam logic [IQ_INST_W-1:0] IQ_NOP = '0;

  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/iq_lane_compact.sv
// -----------------------------------------------------------------------------
// iq_lane_compact
// Drops the lanes of a fetch line that sit below the fetch PC and shifts the
// remaining lanes down, so compacted lane 0 is always the first wanted
// instruction. Purely combinational.
// Ports:
//   fq_pc     in   PC_W            PC of first wanted instruction in the line
//   fq_data   in   FETCH_W         fetch line, lane i = bits [32i+31:32i]
//   lane_inst out  LANES x 32      compacted instructions
//   lane_pc   out  LANES x PC_W    PC of each compacted instruction
//   lane_vld  out  LANES           compacted lane holds a wanted instruction
//   lane_cnt  out  $clog2(LANES+1) number of wanted instructions in the line
// -----------------------------------------------------------------------------
module iq_lane_compact
  import id_inst_queue_pkg::*;
#(
  parameter  int FETCH_W = 64,
  parameter  int PC_W    = 64,
  localparam int LANES   = FETCH_W / IQ_INST_W,
  localparam int CNT_W   = $clog2(LANES + 1)
) (
  input  logic [PC_W-1:0]                     fq_pc,
  input  logic [FETCH_W-1:0]                  fq_data,
  output logic [LANES-1:0][IQ_INST_W-1:0]     lane_inst,
  output logic [LANES-1:0][PC_W-1:0]          lane_pc,
  output logic [LANES-1:0]                    lane_vld,
  output logic [CNT_W-1:0]                    lane_cnt
);

  localparam int LB = lane_bits(LANES);

  logic [LB-1:0]   start;
  logic [PC_W-1:0] line_base;
  // Byte offset within a 32-bit instruction carries no information here.
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^fq_pc[1:0];

  generate
    if (LANES > 1) begin : g_multi_lane
      assign start     = fq_pc[LB+1:2];
      assign line_base = {fq_pc[PC_W-1:LB+2], {(LB + 2){1'b0}}};
    end else begin : g_single_lane
      assign start     = '0;
      assign line_base = {fq_pc[PC_W-1:2], 2'b00};
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lane_inst = '0;
    lane_pc   = '0;
    lane_vld  = '0;
    lane_cnt  = CNT_W'(LANES - int'(start));
    for (int j = 0; j < LANES; j++) begin
      if (j + int'(start) < LANES) begin
        lane_vld[j]  = 1'b1;
        lane_inst[j] = fq_data[(j + int'(start)) * IQ_INST_W +: IQ_INST_W];
        lane_pc[j]   = line_base | (PC_W'(j + int'(start)) << 2);
      end
    end
  end

endmodule

// File: rtl/id_inst_queue.sv
// -----------------------------------------------------------------------------
// id_inst_queue
// Instruction queue between IF and ID. Accepts whole fetch lines, keeps only
// the lanes at or above the fetch PC, buffers up to DEPTH instructions in a
// circular store and hands one per cycle to the decoder over valid/ready.
// Flush empties the queue and blocks both accept and dequeue that cycle.
//
// Optional feature (macro IQ_BYPASS_EN): on an empty queue the first wanted
// lane of an accepted line is driven on id_* in the same cycle; if the decoder
// takes it, it is not written to storage.
//
// Ports:
//   clk       in   1                clock
//   rst       in   1                asynchronous, active-high reset
//   flush     in   1                pipeline redirect; empties queue
//   fq_valid  in   1                fetch line valid
//   fq_ready  out  1                room for a whole line and not flushing
//   fq_pc     in   PC_W             PC of first wanted instruction in line
//   fq_data   in   FETCH_W          fetch line
//   id_valid  out  1                head instruction valid
//   id_ready  in   1                decoder consumes head
//   id_pc     out  PC_W             PC of head (0 when !id_valid)
//   id_inst   out  32               head instruction (0 when !id_valid)
//   count     out  $clog2(DEPTH+1)  occupied slots
// -----------------------------------------------------------------------------
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter  int FETCH_W = 64,
  parameter  int DEPTH   = 8,
  parameter  int PC_W    = 64,
  localparam int LANES   = FETCH_W / IQ_INST_W,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 fq_valid,
  output logic                 fq_ready,
  input  logic [PC_W-1:0]      fq_pc,
  input  logic [FETCH_W-1:0]   fq_data,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [PC_W-1:0]      id_pc,
  output logic [IQ_INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]     count
);

  localparam int LCNT_W = $clog2(LANES + 1);

  logic [LANES-1:0][IQ_INST_W-1:0] lane_inst;
  logic [LANES-1:0][PC_W-1:0]      lane_pc;
  logic [LANES-1:0]                lane_vld;
  logic [LCNT_W-1:0]               lane_cnt;

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [IQ_INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]      mem_pc   [DEPTH];

  logic              stored;
  logic              accept;
  logic              byp_act;
  logic              skip;
  logic              deq;
  logic [CNT_W-1:0]  free_slots;
  logic [LCNT_W-1:0] enq_n;
  logic [CNT_W-1:0]  count_next;

  iq_lane_compact #(
    .FETCH_W (FETCH_W),
    .PC_W    (PC_W)
  ) u_compact (
    .fq_pc     (fq_pc),
    .fq_data   (fq_data),
    .lane_inst (lane_inst),
    .lane_pc   (lane_pc),
    .lane_vld  (lane_vld),
    .lane_cnt  (lane_cnt)
  );

  assign stored     = (count != '0);
  assign free_slots = CNT_W'(DEPTH) - count;
  // Space for a worst-case (all lanes wanted) line; decoder readiness is
  // deliberately ignored to keep id_ready off the IF timing path.
  assign fq_ready   = (free_slots >= CNT_W'(LANES)) && !flush;
  assign accept     = fq_valid && fq_ready;

`ifdef IQ_BYPASS_EN
  assign byp_act = !stored && accept;
`else
  assign byp_act = 1'b0;
`endif

  assign id_valid = (stored || byp_act) && !flush;
  assign id_inst  = !id_valid ? IQ_NOP :
                    stored    ? mem_inst[head] : lane_inst[0];
  assign id_pc    = !id_valid ? '0 :
                    stored    ? mem_pc[head]   : lane_pc[0];

  // A bypassed lane consumed by the decoder never enters storage.
  assign deq        = id_valid && id_ready && stored;
  assign skip       = byp_act && id_ready;
  assign enq_n      = accept ? (lane_cnt - LCNT_W'(skip)) : '0;
  assign count_next = count + CNT_W'(enq_n) - CNT_W'(deq);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(enq_n);
      count <= count_next;
    end
  end

  // NOTE: the storage array has no reset; occupancy lives in count and the
  // outputs are gated by id_valid, so stale slot contents are never visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < LANES; j++) begin
        if (lane_vld[j] && (j >= int'(skip))) begin
          mem_inst[tail + PTR_W'(j - int'(skip))] <= lane_inst[j];
          mem_pc[tail + PTR_W'(j - int'(skip))]   <= lane_pc[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_id_inst_queue
// Directed bench for id_inst_queue (FETCH_W=64, DEPTH=8, PC_W=64).
// Instruction words encode their own PC (16'hC0DE, pc[15:0]) so expected
// id_inst follows from expected id_pc. Expected values that differ with the
// optional same-cycle bypass are written in terms of BYP.
// -----------------------------------------------------------------------------
module tb_id_inst_queue;

  localparam int FETCH_W = 64;
  localparam int DEPTH   = 8;
  localparam int PC_W    = 64;
  localparam int CNT_W   = $clog2(DEPTH + 1);

`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               fq_valid;
  logic               fq_ready;
  logic [PC_W-1:0]    fq_pc;
  logic [FETCH_W-1:0] fq_data;
  logic               id_valid;
  logic               id_ready;
  logic [PC_W-1:0]    id_pc;
  logic [31:0]        id_inst;
  logic [CNT_W-1:0]   count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        fl;
    logic        fv;
    logic [63:0] pc;
    logic [63:0] data;
    logic        rdy;
    logic        e_fr;
    logic        e_iv;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    int          e_cnt;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  id_inst_queue #(
    .FETCH_W (FETCH_W),
    .DEPTH   (DEPTH),
    .PC_W    (PC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .fq_valid (fq_valid),
    .fq_ready (fq_ready),
    .fq_pc    (fq_pc),
    .fq_data  (fq_data),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  function automatic logic [31:0] mk(input logic [63:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  function automatic logic [63:0] line_of(input logic [63:0] pc);
    logic [63:0] base;
    base = pc & ~64'h7;
    return {mk(base + 64'd4), mk(base)};
  endfunction

  // One row: inputs for a cycle and the outputs expected during it.
  function automatic void add(input logic fl, input logic fv, input logic [63:0] pc,
                              input logic rdy, input logic e_fr, input logic e_iv,
                              input logic [63:0] e_pc, input int e_cnt);
    vec_t v;
    v.fl     = fl;
    v.fv     = fv;
    v.pc     = fv ? pc : 64'h0;
    v.data   = fv ? line_of(pc) : JUNK;
    v.rdy    = rdy;
    v.e_fr   = e_fr;
    v.e_iv   = e_iv;
    v.e_pc   = e_iv ? e_pc : 64'h0;
    v.e_inst = e_iv ? mk(e_pc) : 32'h0;
    v.e_cnt  = e_cnt;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic fv, input logic [63:0] pc, input logic rdy);
    flush    = fl;
    fq_valid = fv;
    fq_pc    = fv ? pc : 64'h0;
    fq_data  = fv ? line_of(pc) : JUNK;
    id_ready = rdy;
  endtask

  task automatic check_all(input string tag, input logic e_fr, input logic e_iv,
                           input logic [63:0] e_pc, input logic [31:0] e_inst, input int e_cnt);
    check({tag, "_fq_ready"}, 64'(fq_ready), 64'(e_fr));
    check({tag, "_id_valid"}, 64'(id_valid), 64'(e_iv));
    check({tag, "_id_pc"},    id_pc, e_pc);
    check({tag, "_id_inst"},  64'(id_inst), 64'(e_inst));
    check({tag, "_count"},    64'(count), 64'(e_cnt));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 1'b0);

    // ---- reset state
    #2;
    check_all("reset", 1'b1, 1'b0, 64'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- basic two-lane line, drained in order
    add(0, 1, 64'h8000_0000, 0, 1, BYP, 64'h8000_0000, 0);
    add(0, 0, 64'h0,         1, 1, 1,   64'h8000_0000, 2);
    add(0, 0, 64'h0,         1, 1, 1,   64'h8000_0004, 1);
    add(0, 0, 64'h0,         0, 1, 0,   64'h0,         0);
    // ---- fetch PC on the odd lane: only the upper lane is kept
    add(0, 1, 64'h8000_0004, 0, 1, BYP, 64'h8000_0004, 0);
    add(0, 0, 64'h0,         0, 1, 1,   64'h8000_0004, 1);
    add(0, 0, 64'h0,         1, 1, 1,   64'h8000_0004, 1);
    add(0, 0, 64'h0,         0, 1, 0,   64'h0,         0);
    // ---- fill to DEPTH-1, back-pressure, recover, drain
    add(0, 1, 64'h1000, 0, 1, BYP, 64'h1000, 0);
    add(0, 1, 64'h1008, 0, 1, 1,   64'h1000, 2);
    add(0, 1, 64'h1010, 0, 1, 1,   64'h1000, 4);
    add(0, 1, 64'h101C, 0, 1, 1,   64'h1000, 6);
    add(0, 1, 64'h1020, 0, 0, 1,   64'h1000, 7);
    add(0, 1, 64'h1020, 1, 0, 1,   64'h1000, 7);
    add(0, 0, 64'h0,    0, 1, 1,   64'h1004, 6);
    add(0, 0, 64'h0,    1, 1, 1,   64'h1004, 6);
    add(0, 0, 64'h0,    1, 1, 1,   64'h1008, 5);
    add(0, 0, 64'h0,    1, 1, 1,   64'h100C, 4);
    add(0, 0, 64'h0,    1, 1, 1,   64'h1010, 3);
    add(0, 0, 64'h0,    1, 1, 1,   64'h1014, 2);
    add(0, 0, 64'h0,    1, 1, 1,   64'h101C, 1);
    add(0, 0, 64'h0,    0, 1, 0,   64'h0,    0);
    // ---- wrap: walk tail to slot DEPTH-1, then a line lands in slots 7 and 0;
    //      also same-cycle accept+dequeue, including on the last entry
    add(0, 1, 64'h2000, 0, 1, BYP, 64'h2000, 0);
    add(0, 1, 64'h2008, 1, 1, 1,   64'h2000, 2);
    add(0, 1, 64'h2014, 1, 1, 1,   64'h2004, 3);
    add(0, 0, 64'h0,    1, 1, 1,   64'h2008, 3);
    add(0, 0, 64'h0,    1, 1, 1,   64'h200C, 2);
    add(0, 1, 64'h3000, 1, 1, 1,   64'h2014, 1);
    add(0, 0, 64'h0,    1, 1, 1,   64'h3000, 2);
    add(0, 0, 64'h0,    1, 1, 1,   64'h3004, 1);
    add(0, 0, 64'h0,    0, 1, 0,   64'h0,    0);
    // ---- flush at count 5 with a line offered and decoder ready
    add(0, 1, 64'h4000, 0, 1, BYP, 64'h4000, 0);
    add(0, 1, 64'h4008, 0, 1, 1,   64'h4000, 2);
    add(0, 1, 64'h4014, 0, 1, 1,   64'h4000, 4);
    add(1, 1, 64'h5000, 1, 0, 0,   64'h0,    5);
    add(0, 0, 64'h0,    0, 1, 0,   64'h0,    0);
    add(0, 1, 64'h5000, 0, 1, BYP, 64'h5000, 0);
    add(0, 0, 64'h0,    1, 1, 1,   64'h5000, 2);
    add(0, 0, 64'h0,    1, 1, 1,   64'h5004, 1);
    add(0, 0, 64'h0,    0, 1, 0,   64'h0,    0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].fl, vq[i].fv, vq[i].pc, vq[i].rdy);
      #1;
      check_all($sformatf("row%0d", i), vq[i].e_fr, vq[i].e_iv,
                vq[i].e_pc, vq[i].e_inst, vq[i].e_cnt);
    end

    // ---- empty queue, decoder ready, line offered: bypass vs 1-cycle latency
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h6000, 1'b1);
    #1;
    check("byp_c0_id_valid", 64'(id_valid), 64'(BYP));
    check("byp_c0_id_inst",  64'(id_inst),  64'(BYP ? mk(64'h6000) : 32'h0));
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    check("byp_c1_count",   64'(count),   64'(BYP ? 1 : 2));
    check("byp_c1_id_inst", 64'(id_inst), 64'(BYP ? mk(64'h6004) : mk(64'h6000)));
    @(negedge clk);
    #1;
    check("byp_c2_count",    64'(count),    64'(BYP ? 0 : 1));
    check("byp_c2_id_valid", 64'(id_valid), 64'(!BYP));
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    check("byp_c3_count", 64'(count), 64'(0));

    // ---- reset while holding contents discards everything
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h7000, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    check("pre_rst_count", 64'(count), 64'(2));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("mid_rst", 1'b1, 1'b0, 64'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_all("post_rst", 1'b1, 1'b0, 64'h0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
